// File: rtl/wb_regif_slave.sv
// -----------------------------------------------------------------------------
// wb_regif_slave
//   Wishbone classic slave front-end for a register address decoder.
//   Accepts one bus cycle and presents a registered 16-bit address to the
//   decoder. After a settle cycle and WAIT_STATES extra cycles it samples the
//   decoder's read data and hit flag. It then terminates with a one-cycle ACK
//   (or ERR) and pulses a register read or write strobe.
//
//   Optional feature macro: WB_ERR_EN
//     defined   -> an access that misses every decoder slot terminates with
//                  wb_err_o instead of wb_ack_o. No data and no strobes are
//                  returned for it.
//     undefined -> wb_err_o is held at 0. Unmapped reads ack with the
//                  decoder's data, and unmapped writes ack without reg_wr_o.
//
// Ports
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   wb_cyc_i/stb_i/we_i           Wishbone cycle, strobe, write enable
//   wb_adr_i[ADDR_W], wb_dat_i    word address, write data
//   wb_sel_i[4]                   byte selects
//   wb_dat_o, wb_ack_o, wb_err_o  read data, acknowledge, error terminate
//   dec_addr_o[16]                registered, zero-extended decoder address
//   dec_dat_i, dec_hit_i          decoder read mux data, any-slot-hit flag
//   reg_wdat_o, reg_sel_o         latched write data and byte selects
//   reg_wr_o, reg_rd_o            one-cycle write and read strobes
// -----------------------------------------------------------------------------
module wb_regif_slave #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic [15:0]       dec_addr_o,
    input  logic [31:0]       dec_dat_i,
    input  logic              dec_hit_i,
    output logic [31:0]       reg_wdat_o,
    output logic [3:0]        reg_sel_o,
    output logic              reg_wr_o,
    output logic              reg_rd_o
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_TERM} state_t;

    // Preload value for the wait counter. WAIT is skipped entirely when
    // WAIT_STATES is 0, so the 0 used in that case is never consumed.
    localparam logic [3:0] WS_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rdat_q, rdat_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        wr_q, wr_d;
    logic        rd_q, rd_d;
    logic        go_term;
    logic        unmapped_err;

`ifdef WB_ERR_EN
    assign unmapped_err = ~dec_hit_i;
`else
    assign unmapped_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        rdat_d  = 32'd0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        go_term = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    we_d    = wb_we_i;
                    addr_d  = 16'(wb_adr_i);
                    wdat_d  = wb_dat_i;
                    sel_d   = wb_sel_i;
                    state_d = S_SETUP;
                end
            end
            // Only a dropped cyc aborts. A low stb while cyc is held is a
            // legal classic-cycle wait.
            S_SETUP: begin
                if (!wb_cyc_i) begin
                    state_d = S_IDLE;
                end else if (WAIT_STATES == 0) begin
                    state_d = S_TERM;
                    go_term = 1'b1;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = WS_INIT;
                end
            end
            S_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_TERM;
                    go_term = 1'b1;
                end else begin
                    cnt_d = 4'(cnt_q - 4'd1);
                end
            end
            S_TERM:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The cycle that enters TERM is the decoder sample point. Every
        // termination output is registered here, so all of them appear
        // together for exactly the single TERM cycle.
        if (go_term) begin
            if (unmapped_err) begin
                err_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                if (we_q) begin
                    wr_d = dec_hit_i;
                end else begin
                    rd_d   = 1'b1;
                    rdat_d = dec_dat_i;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 16'd0;
            wdat_q  <= 32'd0;
            sel_q   <= 4'd0;
            rdat_q  <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    assign wb_dat_o   = rdat_q;
    assign wb_ack_o   = ack_q;
    assign wb_err_o   = err_q;
    assign dec_addr_o = addr_q;
    assign reg_wdat_o = wdat_q;
    assign reg_sel_o  = sel_q;
    assign reg_wr_o   = wr_q;
    assign reg_rd_o   = rd_q;

endmodule

// File: tb/tb_wb_regif_slave.sv
// -----------------------------------------------------------------------------
// tb_wb_regif_slave
//   Scoreboard bench for wb_regif_slave. Each request pushes its expected
//   termination (cycle, data, strobes, ack/err) into a queue. A negedge
//   monitor pops and compares each entry when the main DUT terminates, and
//   checks that every strobe stays low in all other cycles. Two extra
//   instances share the bus inputs to cover WAIT_STATES = 0 and 15.
// -----------------------------------------------------------------------------
module tb_wb_regif_slave;

    localparam int WS = 1;
`ifdef WB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] dat;
        bit          rd;
        bit          wr;
        bit          err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [15:0] adr = '0;
    logic [31:0] wdat = '0, ddat = '0;
    logic [3:0]  sel = '0;
    logic        hit = 1'b0;

    logic [31:0] wb_dat_o, reg_wdat_o;
    logic        wb_ack_o, wb_err_o, reg_wr_o, reg_rd_o;
    logic [15:0] dec_addr_o;
    logic [3:0]  reg_sel_o;

    logic [31:0] dat_w0, wdat_w0, dat_w15, wdat_w15;
    logic        ack_w0, err_w0, wr_w0, rd_w0, ack_w15, err_w15, wr_w15, rd_w15;
    logic [15:0] da_w0, da_w15;
    logic [3:0]  sel_w0, sel_w15;

    int   n_chk = 0, n_fail = 0, cyc_cnt = 0;
    exp_t sb[$];
    exp_t e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wb_regif_slave #(.ADDR_W(16), .WAIT_STATES(WS)) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .dec_addr_o(dec_addr_o),
        .dec_dat_i(ddat), .dec_hit_i(hit), .reg_wdat_o(reg_wdat_o),
        .reg_sel_o(reg_sel_o), .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o));

    wb_regif_slave #(.ADDR_W(16), .WAIT_STATES(0)) u_dut_w0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(dat_w0),
        .wb_ack_o(ack_w0), .wb_err_o(err_w0), .dec_addr_o(da_w0),
        .dec_dat_i(ddat), .dec_hit_i(hit), .reg_wdat_o(wdat_w0),
        .reg_sel_o(sel_w0), .reg_wr_o(wr_w0), .reg_rd_o(rd_w0));

    wb_regif_slave #(.ADDR_W(16), .WAIT_STATES(15)) u_dut_w15 (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_dat_o(dat_w15),
        .wb_ack_o(ack_w15), .wb_err_o(err_w15), .dec_addr_o(da_w15),
        .dec_dat_i(ddat), .dec_hit_i(hit), .reg_wdat_o(wdat_w15),
        .reg_sel_o(sel_w15), .reg_wr_o(wr_w15), .reg_rd_o(rd_w15));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Expected termination for an access whose request is sampled in the
    // cycle where cyc_cnt == c0.
    function automatic exp_t mk_exp(input int c0, input bit w, input bit h, input logic [31:0] d);
        exp_t x;
        x.cyc = c0 + 2 + WS;
        x.err = ERR_EN && !h;
        x.dat = (x.err || w) ? 32'd0 : d;
        x.rd  = !x.err && !w;
        x.wr  = !x.err && w && h;
        return x;
    endfunction

    // Drive a request at a negedge. The DUT samples it at the next posedge.
    task automatic start(input bit w, input logic [15:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit h, input logic [31:0] dd, input bit push);
        we = w; adr = a; wdat = d; sel = s; hit = h; ddat = dd;
        cyc = 1'b1; stb = 1'b1;
        if (push) sb.push_back(mk_exp(cyc_cnt, w, h, dd));
    endtask

    task automatic wait_term();
        int n = 0;
        while (!(wb_ack_o || wb_err_o) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("timeout_term", 32'd0, 32'd1);
    endtask

    // Full transfer: stb is held only in the acceptance cycle, cyc until termination.
    task automatic xfer(input bit w, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit h, input logic [31:0] dd);
        start(w, a, d, s, h, dd, 1'b1);
        @(negedge clk);
        stb = 1'b0;
        wait_term();
        cyc = 1'b0;
        @(negedge clk);
    endtask

    // Main-DUT monitor: a termination must match the oldest expectation.
    // Outside termination the strobes and read data must stay at 0.
    always @(negedge clk) begin
        if (wb_ack_o || wb_err_o) begin
            if (sb.size() == 0) begin
                chk("spurious_term", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("term_cycle", cyc_cnt, e.cyc);
                chk("rd_data", wb_dat_o, e.dat);
                chk("ack", {31'd0, wb_ack_o}, {31'd0, !e.err});
                chk("err", {31'd0, wb_err_o}, {31'd0, e.err});
                chk("reg_rd", {31'd0, reg_rd_o}, {31'd0, e.rd});
                chk("reg_wr", {31'd0, reg_wr_o}, {31'd0, e.wr});
            end
        end else begin
            chk("idle_reg_rd", {31'd0, reg_rd_o}, 32'd0);
            chk("idle_reg_wr", {31'd0, reg_wr_o}, 32'd0);
            chk("idle_dat", wb_dat_o, 32'd0);
        end
    end

    initial begin
        int m, f0, f15;
        repeat (3) @(negedge clk);
        chk("rst_dec_addr", {16'd0, dec_addr_o}, 32'd0);
        chk("rst_wdat", reg_wdat_o, 32'd0);
        chk("rst_sel", {28'd0, reg_sel_o}, 32'd0);
        chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: mapped read, address visible in SETUP (cycle 1)
        start(1'b0, 16'h0003, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        stb = 1'b0;
        chk("t1_dec_addr", {16'd0, dec_addr_o}, 32'h0003);
        wait_term();
        cyc = 1'b0;
        @(negedge clk);

        // 2: mapped write, latched data and selects
        xfer(1'b1, 16'h0005, 32'h12345678, 4'hF, 1'b1, 32'hCAFEF00D);
        chk("t2_wdat", reg_wdat_o, 32'h12345678);
        chk("t2_sel", {28'd0, reg_sel_o}, 32'hF);
        chk("t2_dec_addr", {16'd0, dec_addr_o}, 32'h0005);

        // 3: unmapped read and unmapped write, then a partial-select read
        xfer(1'b0, 16'h00FF, 32'h0, 4'hF, 1'b0, 32'h0);
        xfer(1'b1, 16'h00FE, 32'h55AA55AA, 4'h3, 1'b0, 32'h0);
        xfer(1'b0, 16'hFFFF, 32'h0, 4'h1, 1'b1, 32'h0BADCAFE);
        chk("t3_sel", {28'd0, reg_sel_o}, 32'h1);
        chk("t3_dec_addr", {16'd0, dec_addr_o}, 32'hFFFF);

        // 5a: abort in SETUP, then an immediate request must see normal latency
        start(1'b0, 16'h0010, 32'h0, 4'hF, 1'b1, 32'h11111111, 1'b0);
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        xfer(1'b0, 16'h0011, 32'h0, 4'hF, 1'b1, 32'h22222222);

        // 5b: reset while in WAIT drops the transfer and clears every output
        start(1'b0, 16'h0012, 32'hA5A5A5A5, 4'hC, 1'b1, 32'h33333333, 1'b1);
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("t5_rst_dec_addr", {16'd0, dec_addr_o}, 32'd0);
        chk("t5_rst_wdat", reg_wdat_o, 32'd0);
        chk("t5_rst_sel", {28'd0, reg_sel_o}, 32'd0);
        chk("t5_rst_ack", {31'd0, wb_ack_o}, 32'd0);
        chk("t5_rst_err", {31'd0, wb_err_o}, 32'd0);
        rst = 1'b0; cyc = 1'b0;
        @(negedge clk);
        xfer(1'b0, 16'h0013, 32'h0, 4'hF, 1'b1, 32'h44444444);

        // 6: back-to-back reads with stb held across the first termination
        start(1'b0, 16'h0001, 32'h0, 4'hF, 1'b1, 32'hAAAA0001, 1'b1);
        @(negedge clk);
        wait_term();
        adr = 16'h0002; ddat = 32'hBBBB0002;
        sb.push_back(mk_exp(cyc_cnt + 1, 1'b0, 1'b1, 32'hBBBB0002));
        @(negedge clk);
        @(negedge clk);
        stb = 1'b0;
        wait_term();
        cyc = 1'b0;
        repeat (3) @(negedge clk);

        // 4: latency for WAIT_STATES 0 and 15 on the extra instances
        m = cyc_cnt; f0 = -1; f15 = -1;
        start(1'b0, 16'h0001, 32'h0, 4'hF, 1'b1, 32'h0F0F0F0F, 1'b1);
        for (int i = 0; i < 30 && f15 < 0; i++) begin
            @(negedge clk);
            stb = 1'b0;
            if (ack_w0 && f0 < 0) begin
                f0 = cyc_cnt;
                chk("t4_ws0_dat", dat_w0, 32'h0F0F0F0F);
            end
            if (ack_w15) begin
                f15 = cyc_cnt;
                chk("t4_ws15_dat", dat_w15, 32'h0F0F0F0F);
            end
        end
        cyc = 1'b0;
        chk("t4_ws0_latency", f0 - m, 32'd2);
        chk("t4_ws15_latency", f15 - m, 32'd17);
        repeat (3) @(negedge clk);

        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
